// File: rtl/scan_decoder_pkg.sv
// Shared types for the scan decoder: FSM state encoding and mode select values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder; all-zero output when disabled.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module onehot_decoder #(
    parameter int IN_WIDTH = 4
) (
    input  logic                   enable,
    input  logic [IN_WIDTH-1:0]    in,
    output logic [2**IN_WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        if (enable) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Line decoder that either follows 'in' directly or auto-scans lines with a dwell count.
// Latency: 1 cycle from inputs to registered out/index/wrap.
// Backpressure: none; enable=0 blanks out and freezes index/dwell.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int IN_WIDTH = 4,
    parameter int DWELL    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   load,
    input  logic [IN_WIDTH-1:0]    in,
    output logic [2**IN_WIDTH-1:0] out,
    output logic [IN_WIDTH-1:0]    index,
    output logic                   wrap
);

    localparam int OUT_WIDTH = 2**IN_WIDTH;
    localparam int DW        = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);

    localparam logic [DW-1:0]       DWELL_LAST = DW'(DWELL - 1);
    localparam logic [IN_WIDTH-1:0] INDEX_LAST = '1;

    state_t               state;
    state_t               state_nxt;
    logic [IN_WIDTH-1:0]  index_nxt;
    logic [DW-1:0]        dwell;
    logic [DW-1:0]        dwell_nxt;
    logic                 wrap_nxt;
    logic                 line_en;
    logic [OUT_WIDTH-1:0] out_nxt;

    // Stepping only happens when already scanning, so entering SCAN from
    // DIRECT or IDLE shows the held line for its remaining dwell first.
    always_comb begin
        state_nxt = IDLE;
        index_nxt = index;
        dwell_nxt = dwell;
        wrap_nxt  = 1'b0;
        if (enable) begin
            if (mode == MODE_DIRECT) begin
                state_nxt = DIRECT;
                index_nxt = in;
                dwell_nxt = '0;
            end else begin
                state_nxt = SCAN;
                if (load) begin
                    index_nxt = in;
                    dwell_nxt = '0;
                end else if (state == SCAN) begin
                    if (dwell == DWELL_LAST) begin
                        dwell_nxt = '0;
                        index_nxt = index + 1'b1;
                        wrap_nxt  = (index == INDEX_LAST);
                    end else begin
                        dwell_nxt = dwell + 1'b1;
                    end
                end
            end
        end
    end

    assign line_en = (state_nxt != IDLE);

    onehot_decoder #(
        .IN_WIDTH(IN_WIDTH)
    ) u_onehot (
        .enable(line_en),
        .in    (index_nxt),
        .out   (out_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            dwell <= '0;
            out   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
            dwell <= dwell_nxt;
            out   <= out_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: IN_WIDTH=4/DWELL=2 instance plus IN_WIDTH=2/DWELL=1 instance.
module tb_scan_decoder;

    logic clk;
    logic rst;

    logic        a_en, a_mode, a_load;
    logic [3:0]  a_in;
    logic [15:0] a_out;
    logic [3:0]  a_idx;
    logic        a_wrap;

    logic        b_en, b_mode, b_load;
    logic [1:0]  b_in;
    logic [3:0]  b_out;
    logic [1:0]  b_idx;
    logic        b_wrap;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        en;
        logic        mode;
        logic        load;
        logic [3:0]  in;
        logic [15:0] out;
        logic [3:0]  idx;
        logic        wrap;
    } vec_t;

    vec_t vq[$];

    scan_decoder #(.IN_WIDTH(4), .DWELL(2)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .enable(a_en),
        .mode  (a_mode),
        .load  (a_load),
        .in    (a_in),
        .out   (a_out),
        .index (a_idx),
        .wrap  (a_wrap)
    );

    scan_decoder #(.IN_WIDTH(2), .DWELL(1)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .enable(b_en),
        .mode  (b_mode),
        .load  (b_load),
        .in    (b_in),
        .out   (b_out),
        .index (b_idx),
        .wrap  (b_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic en, input logic mode, input logic load, input logic [3:0] in,
                       input logic [15:0] out, input logic [3:0] idx, input logic wrap);
        vec_t v;
        v.en = en; v.mode = mode; v.load = load; v.in = in;
        v.out = out; v.idx = idx; v.wrap = wrap;
        vq.push_back(v);
    endtask

    task automatic chk_a(input string name, input logic [15:0] out, input logic [3:0] idx,
                         input logic wrap);
        chk({name, ".out"}, 32'(a_out), 32'(out));
        chk({name, ".index"}, 32'(a_idx), 32'(idx));
        chk({name, ".wrap"}, 32'(a_wrap), 32'(wrap));
        chk({name, ".onehot"}, 32'($countones(a_out) <= 1), 32'd1);
    endtask

    logic [3:0] b_exp [5];

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_mode = 1'b0; a_load = 1'b0; a_in = 4'h0;
        b_en = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_in = 2'h0;
        b_exp[0] = 4'h1; b_exp[1] = 4'h2; b_exp[2] = 4'h4; b_exp[3] = 4'h8; b_exp[4] = 4'h1;

        //  en    mode  load  in     out       idx    wrap
        add(1'b1, 1'b0, 1'b0, 4'hA, 16'h0400, 4'hA, 1'b0); // direct decode
        add(1'b0, 1'b0, 1'b0, 4'hA, 16'h0000, 4'hA, 1'b0); // disable holds index
        add(1'b1, 1'b0, 1'b0, 4'hE, 16'h4000, 4'hE, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h4000, 4'hE, 1'b0); // enter scan, dwell 0
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h4000, 4'hE, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h8000, 4'hF, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h8000, 4'hF, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0001, 4'h0, 1'b1); // wrap
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0001, 4'h0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0002, 4'h1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'hF, 16'h8000, 4'hF, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h8000, 4'hF, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h8000, 4'hF, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'h3, 16'h0008, 4'h3, 1'b0); // load beats terminal step
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0008, 4'h3, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0010, 4'h4, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'h5, 16'h0020, 4'h5, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0020, 4'h5, 1'b0); // index 5, dwell 1
        add(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 4'h5, 1'b0);
        add(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 4'h5, 1'b0);
        add(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 4'h5, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0020, 4'h5, 1'b0); // resume remaining dwell
        add(1'b1, 1'b1, 1'b0, 4'h0, 16'h0040, 4'h6, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'h2, 16'h0004, 4'h2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 4'h9, 16'h0000, 4'h2, 1'b0); // load ignored while idle
        add(1'b1, 1'b1, 1'b0, 4'h9, 16'h0004, 4'h2, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h9, 16'h0004, 4'h2, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'h9, 16'h0008, 4'h3, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'h7, 16'h0080, 4'h7, 1'b0); // scan -> direct mid-dwell

        #2;
        chk_a("reset_a", 16'h0000, 4'h0, 1'b0);
        chk("reset_b.out", 32'(b_out), 32'h0);
        chk("reset_b.index", 32'(b_idx), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_a("post_reset_idle", 16'h0000, 4'h0, 1'b0);

        foreach (vq[i]) begin
            a_en = vq[i].en; a_mode = vq[i].mode; a_load = vq[i].load; a_in = vq[i].in;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vq[i].out, vq[i].idx, vq[i].wrap);
        end

        // asynchronous reset in the middle of a scan at index 9
        a_en = 1'b1; a_mode = 1'b0; a_load = 1'b0; a_in = 4'h9;
        @(posedge clk); #1;
        chk_a("pre_rst_direct", 16'h0200, 4'h9, 1'b0);
        a_mode = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_a("pre_rst_scan", 16'h0200, 4'h9, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_a("async_reset", 16'h0000, 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_a("after_rst_0a", 16'h0001, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk_a("after_rst_0b", 16'h0001, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk_a("after_rst_1", 16'h0002, 4'h1, 1'b0);

        // DWELL=1, IN_WIDTH=2 instance: step every cycle
        a_en = 1'b0;
        b_en = 1'b1; b_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b_out%0d", i), 32'(b_out), 32'(b_exp[i]));
            chk($sformatf("b_wrap%0d", i), 32'(b_wrap), 32'(i == 4));
            chk($sformatf("b_onehot%0d", i), 32'($countones(b_out) == 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
